// File: rtl/xor_pkg.sv
// Shared definitions for the serial XOR parity accumulator: FSM encoding and
// result counter width.
package xor_pkg;

    localparam int unsigned FRAME_CNT_W = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_e;

endpackage

// File: rtl/xor_frame_ctr.sv
// Wrapping counter of consumed frame parity results.
module xor_frame_ctr
    import xor_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   inc,
    output logic [FRAME_CNT_W-1:0] count
);

    logic [FRAME_CNT_W-1:0] r_count;

    // Natural modulo-2^W wrap on overflow
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (inc) begin
            r_count <= r_count + FRAME_CNT_W'(1);
        end
    end

    assign count = r_count;

endmodule

// File: rtl/xor_parity_acc.sv
// Accumulates FRAME_LEN serial bits into one parity result and hands it to a
// valid/ready consumer; a pop can overlap the first bit of the next frame.
module xor_parity_acc
    import xor_pkg::*;
#(
    parameter int unsigned FRAME_LEN = 8,
    parameter bit          ODD       = 1'b0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    input  logic                   in_bit,
    output logic                   in_ready,
    input  logic                   flush,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   out_parity,
    output logic [FRAME_CNT_W-1:0] frame_cnt,
    output logic                   busy
);

    localparam int unsigned      BCW  = $clog2(FRAME_LEN) + 1;
    localparam logic [BCW-1:0]   LAST = BCW'(FRAME_LEN - 1);

    state_e         r_state;
    logic           r_par;
    logic [BCW-1:0] r_bitcnt;
    logic           r_out_valid;
    logic           r_out_parity;

    state_e         w_state_nxt;
    logic           w_par_nxt;
    logic [BCW-1:0] w_bitcnt_nxt;
    logic           w_valid_nxt;
    logic           w_parity_nxt;
    logic           w_inc;
    logic           w_in_ready;
    logic           w_accept;

    // Only a pending result can stall the input, and only while it is not taken
    assign w_in_ready = (r_state == HOLD) ? out_ready : 1'b1;
    assign w_accept   = in_valid & w_in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_par_nxt    = r_par;
        w_bitcnt_nxt = r_bitcnt;
        w_valid_nxt  = r_out_valid;
        w_parity_nxt = r_out_parity;
        w_inc        = 1'b0;

        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_par_nxt    = in_bit;
                    w_bitcnt_nxt = BCW'(1);
                    w_state_nxt  = ACCUM;
                end
            end
            ACCUM: begin
                if (flush) begin
                    w_par_nxt    = 1'b0;
                    w_bitcnt_nxt = '0;
                    w_state_nxt  = IDLE;
                end else if (w_accept) begin
                    if (r_bitcnt == LAST) begin
                        w_parity_nxt = r_par ^ in_bit ^ ODD;
                        w_valid_nxt  = 1'b1;
                        w_par_nxt    = 1'b0;
                        w_bitcnt_nxt = '0;
                        w_state_nxt  = HOLD;
                    end else begin
                        w_par_nxt    = r_par ^ in_bit;
                        w_bitcnt_nxt = r_bitcnt + BCW'(1);
                    end
                end
            end
            HOLD: begin
                // Flush never touches the pending result, but drops a same-cycle bit
                if (r_out_valid && out_ready) begin
                    w_valid_nxt = 1'b0;
                    w_inc       = 1'b1;
                    if (w_accept && !flush) begin
                        w_par_nxt    = in_bit;
                        w_bitcnt_nxt = BCW'(1);
                        w_state_nxt  = ACCUM;
                    end else begin
                        w_state_nxt  = IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_par        <= 1'b0;
            r_bitcnt     <= '0;
            r_out_valid  <= 1'b0;
            r_out_parity <= 1'b0;
        end else begin
            r_par        <= w_par_nxt;
            r_bitcnt     <= w_bitcnt_nxt;
            r_out_valid  <= w_valid_nxt;
            r_out_parity <= w_parity_nxt;
        end
    end

    xor_frame_ctr u_frame_ctr (
        .clk   (clk),
        .rst   (rst),
        .inc   (w_inc),
        .count (frame_cnt)
    );

    assign in_ready   = w_in_ready;
    assign out_valid  = r_out_valid;
    assign out_parity = r_out_parity;
    assign busy       = (r_state != IDLE);

endmodule

// File: tb/tb_xor_parity_acc.sv
// Scoreboard bench for xor_parity_acc: even and odd instances share stimulus,
// a frame-level model predicts results, a negedge monitor checks them.
module tb_xor_parity_acc;
    import xor_pkg::*;

    localparam int unsigned FL = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, in_valid, in_bit, flush, out_ready;
    logic ir0, ov0, op0, bz0, ir1, ov1, op1, bz1;
    logic [15:0] fc0, fc1;

    logic c_rst, c_inc;
    logic [15:0] c_count;
    bit ctr_done = 1'b0;

    int checks   = 0;
    int failures = 0;
    bit mon_en   = 1'b0;

    // Reference model state, describing the DUT after the most recent edge
    bit          m_pending = 1'b0;
    logic [15:0] m_cnt     = 16'd0;
    logic        m_bits[$];
    logic        m_exp[$];

    xor_parity_acc #(.FRAME_LEN(FL), .ODD(1'b0)) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_bit(in_bit),
        .in_ready(ir0), .flush(flush), .out_valid(ov0), .out_ready(out_ready),
        .out_parity(op0), .frame_cnt(fc0), .busy(bz0)
    );

    xor_parity_acc #(.FRAME_LEN(FL), .ODD(1'b1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_bit(in_bit),
        .in_ready(ir1), .flush(flush), .out_valid(ov1), .out_ready(out_ready),
        .out_parity(op1), .frame_cnt(fc1), .busy(bz1)
    );

    xor_frame_ctr u_ctr (
        .clk(clk), .rst(c_rst), .inc(c_inc), .count(c_count)
    );

    task automatic chk1(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%b required=%b t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk16(input string nm, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Frame-level behaviour for the inputs sampled at the edge just passed
    task automatic model_step();
        logic acc;
        logic p;
        if (rst) begin
            m_bits.delete();
            m_exp.delete();
            m_pending = 1'b0;
            m_cnt     = 16'd0;
        end else begin
            acc = in_valid && (!m_pending || out_ready);
            if (m_pending) begin
                if (out_ready) begin
                    m_pending = 1'b0;
                    m_cnt     = m_cnt + 16'd1;
                    if (acc && !flush) m_bits.push_back(in_bit);
                end
            end else if (flush && m_bits.size() != 0) begin
                m_bits.delete();
            end else if (acc) begin
                m_bits.push_back(in_bit);
                if (m_bits.size() == FL) begin
                    p = 1'b0;
                    foreach (m_bits[k]) p = p ^ m_bits[k];
                    m_exp.push_back(p);
                    m_pending = 1'b1;
                    m_bits.delete();
                end
            end
        end
    endtask

    task automatic drive(input logic r, input logic v, input logic b,
                         input logic f, input logic o);
        rst = r; in_valid = v; in_bit = b; flush = f; out_ready = o;
        @(posedge clk);
        #1;
        model_step();
    endtask

    task automatic send(input logic b, input logic o);
        drive(1'b0, 1'b1, b, 1'b0, o);
    endtask

    task automatic idle(input logic o);
        drive(1'b0, 1'b0, 1'b0, 1'b0, o);
    endtask

    // Monitor: compare every cycle, pop a result whenever the consumer takes it
    always @(negedge clk) begin
        if (mon_en) begin
            chk1("out_valid_even", ov0, m_pending);
            chk1("out_valid_odd", ov1, m_pending);
            chk1("in_ready", ir0, !m_pending || out_ready);
            chk1("busy", bz0, m_pending || (m_bits.size() != 0));
            chk16("frame_cnt_even", fc0, m_cnt);
            chk16("frame_cnt_odd", fc1, m_cnt);
            if (ov0) begin
                if (m_exp.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL scoreboard actual=out_valid required=no_result t=%0t", $time);
                end else begin
                    chk1("parity_even", op0, m_exp[0]);
                    chk1("parity_odd", op1, ~m_exp[0]);
                    if (out_ready && !rst) void'(m_exp.pop_front());
                end
            end
        end
    end

    // Counter wrap runs alongside the main sequence
    initial begin
        c_rst = 1'b1;
        c_inc = 1'b0;
        @(posedge clk);
        #1;
        c_rst = 1'b0;
        chk16("ctr_reset", c_count, 16'h0000);
        c_inc = 1'b1;
        repeat (65535) @(posedge clk);
        #1;
        chk16("ctr_ffff", c_count, 16'hFFFF);
        @(posedge clk);
        #1;
        chk16("ctr_wrap", c_count, 16'h0000);
        c_inc = 1'b0;
        @(posedge clk);
        #1;
        chk16("ctr_hold", c_count, 16'h0000);
        ctr_done = 1'b1;
    end

    initial begin
        logic b2b[8] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        logic r, v, b, f, o;

        rst = 1'b1; in_valid = 1'b0; in_bit = 1'b0; flush = 1'b0; out_ready = 1'b1;
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        mon_en = 1'b1;
        chk1("reset_out_valid", ov0, 1'b0);
        chk1("reset_in_ready", ir0, 1'b1);
        chk1("reset_busy", bz0, 1'b0);
        chk16("reset_frame_cnt", fc0, 16'd0);

        // Single frame 1,0,1,1
        idle(1'b1);
        send(1'b1, 1'b1); send(1'b0, 1'b1); send(1'b1, 1'b1); send(1'b1, 1'b1);
        chk1("frame_valid", ov0, 1'b1);
        chk1("frame_parity_even", op0, 1'b1);
        chk1("frame_parity_odd", op1, 1'b0);
        idle(1'b1);
        chk16("frame_cnt_after_1", fc0, 16'd1);

        // Backpressure with offered bits ignored
        send(1'b1, 1'b0); send(1'b0, 1'b0); send(1'b0, 1'b0); send(1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
            chk1("bp_valid", ov0, 1'b1);
            chk1("bp_parity", op0, 1'b1);
            chk1("bp_in_ready", ir0, 1'b0);
            chk16("bp_frame_cnt", fc0, 16'd1);
        end
        idle(1'b1);
        chk16("bp_release_cnt", fc0, 16'd2);

        // Back-to-back frames with zero bubble
        for (int i = 0; i < 8; i++) begin
            send(b2b[i], 1'b1);
            if (i == 3) chk1("b2b_parity1", op0, 1'b0);
            if (i == 4) begin
                chk1("b2b_overlap_busy", bz0, 1'b1);
                chk1("b2b_overlap_valid", ov0, 1'b0);
                chk16("b2b_overlap_cnt", fc0, 16'd3);
            end
            if (i == 7) chk1("b2b_parity2", op0, 1'b1);
        end
        idle(1'b1);
        chk16("b2b_cnt", fc0, 16'd4);

        // Flush mid-frame with a discarded bit
        send(1'b1, 1'b1); send(1'b1, 1'b1);
        drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
        chk1("flush_busy", bz0, 1'b0);
        send(1'b1, 1'b1); send(1'b0, 1'b1); send(1'b0, 1'b1); send(1'b0, 1'b1);
        chk1("flush_parity", op0, 1'b1);
        idle(1'b1);
        chk16("flush_cnt", fc0, 16'd5);

        // Reset mid-frame, then reset with a result pending
        send(1'b1, 1'b1); send(1'b1, 1'b1); send(1'b1, 1'b1);
        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        chk1("rst_mid_busy", bz0, 1'b0);
        chk1("rst_mid_in_ready", ir0, 1'b1);
        chk16("rst_mid_cnt", fc0, 16'd0);
        send(1'b0, 1'b0); send(1'b1, 1'b0); send(1'b0, 1'b0); send(1'b0, 1'b0);
        chk1("rst_hold_pre_valid", ov0, 1'b1);
        drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        chk1("rst_hold_valid", ov0, 1'b0);
        chk1("rst_hold_parity", op0, 1'b0);
        chk1("rst_hold_busy", bz0, 1'b0);
        chk16("rst_hold_cnt", fc0, 16'd0);

        // Randomised traffic
        for (int i = 0; i < 600; i++) begin
            r = ($urandom_range(99) == 0);
            v = ($urandom_range(3) != 0);
            b = 1'($urandom_range(1));
            f = ($urandom_range(19) == 0);
            o = ($urandom_range(9) < 7);
            drive(r, v, b, f, o);
        end
        repeat (4) idle(1'b1);

        for (int k = 0; k < 70000 && !ctr_done; k++) @(posedge clk);
        if (!ctr_done) begin
            checks++;
            failures++;
            $display("FAIL ctr_timeout actual=not_done required=done");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
